// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add MUL and restoring DIV/DIVU/REM/REMU,
// one iteration per clock, with fast paths for divide-by-zero, signed overflow and bad op codes.
module muldiv_sequencer #(
    parameter int XLEN = 32,
    parameter int CW   = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            inv_op
);

    localparam logic [2:0] OP_MUL = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [2:0]      op_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] acc_q;      // product accumulator / partial remainder
    logic [XLEN-1:0] mq_q;       // multiplier / dividend shifting into quotient
    logic [XLEN-1:0] md_q;       // multiplicand / divisor magnitude
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic [XLEN-1:0] pend_q;
    logic [XLEN-1:0] result_q;
    logic            done_q;
    logic            inv_q;

    logic            op_valid;
    logic            op_signed;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            take_fast;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        op_valid  = (op == OP_MUL) || op[2];
        op_signed = op[2] & ~op[0];
        rs1_neg   = op_signed & rs1_val[XLEN-1];
        rs2_neg   = op_signed & rs2_val[XLEN-1];
        rs1_mag   = rs1_neg ? -rs1_val : rs1_val;
        rs2_mag   = rs2_neg ? -rs2_val : rs2_val;
        div_zero  = (rs2_val == '0);
        div_ovf   = op_signed && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
        take_fast = !op_valid || (op[2] && (div_zero || div_ovf));
        fast_res  = '0;
        if (op_valid && div_zero)
            fast_res = op[1] ? rs1_val : '1;
        else if (op_valid && div_ovf)
            fast_res = op[1] ? '0 : rs1_val;
    end

    logic [XLEN-1:0] mul_sum;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   sub;
    logic            sub_ok;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] final_res;
    logic            last_iter;

    // Remainder stays below the divisor, so an XLEN+1 bit difference never overflows.
    always_comb begin
        mul_sum   = mq_q[0] ? (acc_q + md_q) : acc_q;
        rem_shift = {acc_q, mq_q[XLEN-1]};
        sub       = rem_shift - {1'b0, md_q};
        sub_ok    = ~sub[XLEN];
        rem_next  = sub_ok ? sub[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_next  = {mq_q[XLEN-2:0], sub_ok};
        last_iter = (cnt_q == CW'(XLEN-1));
        if (op_q == OP_MUL)
            final_res = mul_sum;
        else if (op_q[1])
            final_res = neg_rem_q ? -rem_next : rem_next;
        else
            final_res = neg_quo_q ? -quo_next : quo_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            md_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            pend_q    <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_q      <= op;
                        cnt_q     <= '0;
                        neg_quo_q <= rs1_neg ^ rs2_neg;
                        neg_rem_q <= rs1_neg;
                        acc_q     <= '0;
                        mq_q      <= (op == OP_MUL) ? rs2_val : rs1_mag;
                        md_q      <= (op == OP_MUL) ? rs1_val : rs2_mag;
                        if (take_fast) begin
                            pend_q  <= fast_res;
                            inv_q   <= !op_valid;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            inv_q   <= 1'b0;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (op_q == OP_MUL) begin
                            acc_q <= mul_sum;
                            md_q  <= md_q << 1;
                            mq_q  <= mq_q >> 1;
                        end else begin
                            acc_q <= rem_next;
                            mq_q  <= quo_next;
                        end
                        if (last_iter) begin
                            pend_q  <= final_res;
                            inv_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // A flush in the done cycle discards the result and keeps the old one.
                    if (!flush)
                        result_q <= pend_q;
                    inv_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q & ~flush;
    assign inv_op = inv_q & done;
    assign result = (state_q == S_DONE && !flush) ? pend_q : result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M vectors, fast paths, flush, reset and start-while-busy.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy;
    logic        done;
    logic        inv_op;
    logic [31:0] result;

    muldiv_sequencer #(.XLEN(32), .CW(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs1_val (rs1),
        .rs2_val (rs2),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .inv_op  (inv_op)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        inv;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: actual=done(result=%h) required=no done", result);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_result"}, result, mon_e.res);
                chk({mon_e.name, "_inv_op"}, {31'b0, inv_op}, {31'b0, mon_e.inv});
                chk({mon_e.name, "_latency"}, cyc - mon_e.acc + 1, mon_e.lat);
                $display("txn %s: result=%h inv_op=%0b latency=%0d", mon_e.name, result, inv_op,
                         cyc - mon_e.acc + 1);
            end
        end
    end

    task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ei, input int el, input bit hold);
        int n;
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        sb.push_back('{er, ei, el, cyc, nm});
        chk({nm, "_busy"}, {31'b0, busy}, 32'd1);
        if (!hold) start = 1'b0;
        else begin
            op = 3'b001; rs1 = ~a; rs2 = b + 32'd1;
        end
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            if (done) start = 1'b0;
            n++;
        end
        start = 1'b0;
        if (n >= 60) begin
            total++;
            $display("FAIL %s_timeout: actual=busy after 60 cycles required=idle", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=no finish required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev;
        @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_inv", {31'b0, inv_op}, 32'd0);
        chk("reset_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, 1'b0);
        issue("div_-7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);
        issue("rem_-7%2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
        issue("div_7/-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);
        issue("rem_7%-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 33, 1'b0);
        issue("divu_100/7", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1'b0);
        issue("remu_100%7", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 33, 1'b0);
        issue("divu_5/0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);
        issue("remu_5%0", 3'b111, 32'd5, 32'd0, 32'd5, 1'b0, 1, 1'b0);
        issue("rem_-5%0", 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b0, 1, 1'b0);
        issue("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 1'b0);
        issue("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 1'b0);
        issue("bad_op", 3'b001, 32'd9, 32'd3, 32'd0, 1'b1, 1, 1'b0);
        issue("mul_hold", 3'b000, 32'd1000, 32'd1000, 32'h000F_4240, 1'b0, 33, 1'b1);
        chk("hold_idle", {31'b0, busy}, 32'd0);

        // Flush after ten iterations: no done, previous result held.
        prev = 32'h000F_4240;
        start = 1'b1; op = 3'b000; rs1 = 32'd3; rs2 = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_result", result, prev);
        repeat (3) @(negedge clk);

        start = 1'b1; flush = 1'b1; op = 3'b101; rs1 = 32'd8; rs2 = 32'd2;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        chk("flush_start_idle", {31'b0, busy}, 32'd0);

        start = 1'b1; op = 3'b100; rs1 = 32'hFFFF_FF9C; rs2 = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        issue("mul_after_rst", 3'b000, 32'd1000, 32'd1000, 32'h000F_4240, 1'b0, 33, 1'b0);
        issue("remu_b2b", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 33, 1'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
